// File: rtl/ts_fm_mixer.sv
// ts_fm_mixer: TurboSound-FM chip select, bus steering and time-multiplexed stereo mixer (STEREO_MODE_EN adds the stereo layout register)
module ts_fm_mixer #(
  parameter int NCHIPS = 2,
  parameter int OUT_W = 16
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     CE_SAMPLE,
  input  logic                     BDIR,
  input  logic                     BC,
  input  logic [7:0]               DI,
  output logic [7:0]               DO,
  input  logic [8*NCHIPS-1:0]      CHIP_DO,
  output logic [NCHIPS-1:0]        CHIP_WE,
  output logic [NCHIPS-1:0]        CHIP_A0,
  input  logic [8*NCHIPS-1:0]      PSG_A,
  input  logic [8*NCHIPS-1:0]      PSG_B,
  input  logic [8*NCHIPS-1:0]      PSG_C,
  input  logic [12*NCHIPS-1:0]     FM,
  input  logic [NCHIPS-1:0]        PSG_ACT,
  output logic                     FM_ENA,
  output logic signed [OUT_W-1:0]  CHANNEL_L,
  output logic signed [OUT_W-1:0]  CHANNEL_R,
  output logic                     SAMPLE_VALID,
  output logic                     CLIP,
  output logic                     OVERRUN,
  output logic                     ACTIVE
);
  localparam int SW = NCHIPS > 1 ? $clog2(NCHIPS) : 1;
  localparam int AW = 14 + $clog2(NCHIPS);
  localparam int CW = AW > OUT_W ? AW : OUT_W;
  localparam logic signed [CW-1:0] MAXV = {{(CW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [CW-1:0] MINV = ~MAXV;
  localparam logic [SW-1:0] SEL_RST = SW'(NCHIPS >= 2 ? 1 : 0);
  localparam logic [SW-1:0] LAST = SW'(NCHIPS - 1);
  typedef enum logic [1:0] {IDLE, ACCUM, SAT, OUT} state_t;
  state_t state, state_nx;
  logic [SW-1:0] sel, idx;
  logic stat_sel, fm_ena, lat_fm, cmd;
  logic [1:0] lat_mode;
  logic signed [AW-1:0] acc_l, acc_r, pa, pb, pc, fv, pl, pr, add_l, add_r;
  logic signed [CW-1:0] xl, xr;
  logic hi_l, lo_l, hi_r, lo_r;
`ifdef STEREO_MODE_EN
  logic [1:0] mode;
`else
  assign lat_mode = 2'd0;
`endif
  assign FM_ENA = fm_ena;
  assign ACTIVE = (|PSG_ACT) | fm_ena;
  // bus steering: write enables, address lines and read-back mux follow the selected chip
  always_comb begin
    cmd = BDIR & BC;
    DO = CHIP_DO[sel*8 +: 8];
    CHIP_WE = '0;
    CHIP_A0 = '0;
    for (int i = 0; i < NCHIPS; i++) begin
      CHIP_WE[i] = BDIR & (sel == SW'(i));
      CHIP_A0[i] = (BDIR & (sel == SW'(i))) ? ~BC : stat_sel;
    end
  end
  // command decode: select, status-select, FM enable and stereo layout registers
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      sel <= SEL_RST;
      stat_sel <= 1'b1;
      fm_ena <= 1'b0;
`ifdef STEREO_MODE_EN
      mode <= 2'd0;
`endif
    end else if (cmd) begin
      if (DI[7:3] == 5'b11111) begin
        if (NCHIPS >= 2) sel <= SW'(DI[0]);
        stat_sel <= DI[1];
        fm_ena <= ~DI[2];
      end
      if (DI[7:3] == 5'b11100 && int'(DI[2:0]) < NCHIPS) sel <= DI[SW-1:0];
`ifdef STEREO_MODE_EN
      if (DI[7:2] == 6'b110100) mode <= DI[1:0];
`endif
    end
  // contribution of the chip currently addressed by idx, plus saturation of the running sums
  always_comb begin
    pa = {{(AW-8){1'b0}}, PSG_A[idx*8 +: 8]};
    pb = {{(AW-8){1'b0}}, PSG_B[idx*8 +: 8]};
    pc = {{(AW-8){1'b0}}, PSG_C[idx*8 +: 8]};
    fv = lat_fm ? {{(AW-12){FM[idx*12+11]}}, FM[idx*12 +: 12]} : '0;
    pl = lat_mode == 2'd1 ? pa + pa + pc : lat_mode == 2'd2 ? pa + pb + pc : pa + pa + pb;
    pr = lat_mode == 2'd1 ? pb + pb + pc : lat_mode == 2'd2 ? pa + pb + pc : pc + pc + pb;
    add_l = (PSG_ACT[idx] ? pl : '0) + fv;
    add_r = (PSG_ACT[idx] ? pr : '0) + fv;
    xl = CW'(acc_l);
    xr = CW'(acc_r);
    hi_l = xl > MAXV;
    lo_l = xl < MINV;
    hi_r = xr > MAXV;
    lo_r = xr < MINV;
  end
  // pass sequencer next state
  always_comb begin
    state_nx = state == IDLE ? (CE_SAMPLE ? ACCUM : IDLE) :
               state == ACCUM ? (idx == LAST ? SAT : ACCUM) :
               state == SAT ? OUT : IDLE;
  end
  // pass sequencer state register
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) state <= IDLE;
    else state <= state_nx;
  // accumulation, latched pass settings and registered sample outputs
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      idx <= '0;
      acc_l <= '0;
      acc_r <= '0;
      lat_fm <= 1'b0;
`ifdef STEREO_MODE_EN
      lat_mode <= 2'd0;
`endif
      CHANNEL_L <= '0;
      CHANNEL_R <= '0;
      SAMPLE_VALID <= 1'b0;
      CLIP <= 1'b0;
      OVERRUN <= 1'b0;
    end else begin
      OVERRUN <= CE_SAMPLE & (state != IDLE);
      SAMPLE_VALID <= state == SAT;
      if (state == IDLE && CE_SAMPLE) begin
        idx <= '0;
        acc_l <= '0;
        acc_r <= '0;
        lat_fm <= fm_ena;
`ifdef STEREO_MODE_EN
        lat_mode <= mode;
`endif
      end
      if (state == ACCUM) begin
        acc_l <= acc_l + add_l;
        acc_r <= acc_r + add_r;
        idx <= idx + 1'b1;
      end
      if (state == SAT) begin
        CHANNEL_L <= hi_l ? MAXV[OUT_W-1:0] : lo_l ? MINV[OUT_W-1:0] : xl[OUT_W-1:0];
        CHANNEL_R <= hi_r ? MAXV[OUT_W-1:0] : lo_r ? MINV[OUT_W-1:0] : xr[OUT_W-1:0];
        CLIP <= hi_l | lo_l | hi_r | lo_r;
      end
    end
endmodule

// File: tb/tb_ts_fm_mixer.sv
// tb_ts_fm_mixer: randomized self-checking bench for ts_fm_mixer against an arithmetic reference model
module tb_ts_fm_mixer;
  localparam int NC = 4;
  localparam int OW = 12;
  localparam int LAT = NC + 2;
  localparam int MAXO = (1 << (OW - 1)) - 1;
  localparam int MINO = -(1 << (OW - 1));
  logic CLK = 1'b0;
  logic RESET, CE_SAMPLE, BDIR, BC;
  logic [7:0] DI, DO;
  logic [8*NC-1:0] CHIP_DO, PSG_A, PSG_B, PSG_C;
  logic [12*NC-1:0] FM;
  logic [NC-1:0] PSG_ACT, CHIP_WE, CHIP_A0;
  logic FM_ENA, SAMPLE_VALID, CLIP, OVERRUN, ACTIVE;
  logic signed [OW-1:0] CHANNEL_L, CHANNEL_R;
  int checks = 0;
  int errors = 0;
  int m_sel, m_stat, m_fm, m_mode;
  int ca[NC], cb[NC], cc[NC], cf[NC];
  bit cact[NC];

  ts_fm_mixer #(.NCHIPS(NC), .OUT_W(OW)) dut (
    .CLK(CLK), .RESET(RESET), .CE_SAMPLE(CE_SAMPLE), .BDIR(BDIR), .BC(BC), .DI(DI), .DO(DO),
    .CHIP_DO(CHIP_DO), .CHIP_WE(CHIP_WE), .CHIP_A0(CHIP_A0), .PSG_A(PSG_A), .PSG_B(PSG_B),
    .PSG_C(PSG_C), .FM(FM), .PSG_ACT(PSG_ACT), .FM_ENA(FM_ENA), .CHANNEL_L(CHANNEL_L),
    .CHANNEL_R(CHANNEL_R), .SAMPLE_VALID(SAMPLE_VALID), .CLIP(CLIP), .OVERRUN(OVERRUN), .ACTIVE(ACTIVE)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic model_reset();
    m_sel = 1;
    m_stat = 1;
    m_fm = 0;
    m_mode = 0;
  endtask

  function automatic void model_cmd(input logic [7:0] d);
    if (d[7:3] == 5'b11111) begin
      m_sel = int'(d[0]);
      m_stat = int'(d[1]);
      m_fm = d[2] ? 0 : 1;
    end else if (d[7:3] == 5'b11100) begin
      if (int'(d[2:0]) < NC) m_sel = int'(d[2:0]);
    end
`ifdef STEREO_MODE_EN
    else if (d[7:2] == 6'b110100) m_mode = int'(d[1:0]);
`endif
  endfunction

  function automatic void model_mix(input int fm_on, input int md, output int l, output int r, output bit clp);
    l = 0;
    r = 0;
    for (int i = 0; i < NC; i++) begin
      if (cact[i]) begin
        if (md == 1) begin
          l += 2 * ca[i] + cc[i];
          r += 2 * cb[i] + cc[i];
        end else if (md == 2) begin
          l += ca[i] + cb[i] + cc[i];
          r += ca[i] + cb[i] + cc[i];
        end else begin
          l += 2 * ca[i] + cb[i];
          r += 2 * cc[i] + cb[i];
        end
      end
      if (fm_on != 0) begin
        l += cf[i];
        r += cf[i];
      end
    end
    clp = l > MAXO || l < MINO || r > MAXO || r < MINO;
    l = l > MAXO ? MAXO : l < MINO ? MINO : l;
    r = r > MAXO ? MAXO : r < MINO ? MINO : r;
  endfunction

  function automatic logic [7:0] rand_cmd();
    int s = $urandom_range(0, 3);
    logic [7:0] d = 8'($urandom);
    return s == 0 ? {5'b11111, d[2:0]} : s == 1 ? {5'b11100, d[2:0]} : s == 2 ? {6'b110100, d[1:0]} : d;
  endfunction

  task automatic load();
    for (int i = 0; i < NC; i++) begin
      PSG_A[i*8 +: 8] = 8'(ca[i]);
      PSG_B[i*8 +: 8] = 8'(cb[i]);
      PSG_C[i*8 +: 8] = 8'(cc[i]);
      FM[i*12 +: 12] = 12'(cf[i]);
      PSG_ACT[i] = cact[i];
    end
  endtask

  task automatic clear_chips();
    for (int i = 0; i < NC; i++) begin
      ca[i] = 0;
      cb[i] = 0;
      cc[i] = 0;
      cf[i] = 0;
      cact[i] = 1'b0;
    end
  endtask

  task automatic rand_chips();
    int sh = $urandom_range(0, 4);
    for (int i = 0; i < NC; i++) begin
      ca[i] = $urandom_range(0, 255) >> sh;
      cb[i] = $urandom_range(0, 255) >> sh;
      cc[i] = $urandom_range(0, 255) >> sh;
      cf[i] = (int'($urandom_range(0, 4095)) - 2048) >>> sh;
      cact[i] = 1'($urandom_range(0, 1));
    end
    load();
  endtask

  task automatic do_cmd(input logic [7:0] d);
    BDIR = 1'b1;
    BC = 1'b1;
    DI = d;
    step();
    model_cmd(d);
    BDIR = 1'b0;
    BC = 1'b0;
  endtask

  task automatic run_pass(input int ce_again, input int rst_at, input bit cmd_en, input logic [7:0] cmd_d,
                          output int lat, output int nvalid, output int ovr_at,
                          output logic signed [OW-1:0] l, output logic signed [OW-1:0] r, output logic clp);
    lat = -1;
    nvalid = 0;
    ovr_at = -1;
    l = '0;
    r = '0;
    clp = 1'b0;
    CE_SAMPLE = 1'b1;
    if (cmd_en) begin
      BDIR = 1'b1;
      BC = 1'b1;
      DI = cmd_d;
    end
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == 1 && cmd_en) begin
        model_cmd(cmd_d);
        BDIR = 1'b0;
        BC = 1'b0;
      end
      if (SAMPLE_VALID) begin
        nvalid++;
        if (lat < 0) begin
          lat = k;
          l = CHANNEL_L;
          r = CHANNEL_R;
          clp = CLIP;
        end
      end
      if (OVERRUN && ovr_at < 0) ovr_at = k;
      CE_SAMPLE = k == ce_again;
      RESET = k == rst_at;
      if (k == rst_at) model_reset();
    end
    CE_SAMPLE = 1'b0;
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    CE_SAMPLE = 1'b0;
    BDIR = 1'b0;
    BC = 1'b0;
    DI = 8'h00;
    CHIP_DO = $urandom;
    clear_chips();
    load();
    step();
    step();
    model_reset();
    checks++; if (CHANNEL_L !== '0 || CHANNEL_R !== '0) begin errors++; $display("FAIL reset_channels got %0d/%0d expected 0/0", CHANNEL_L, CHANNEL_R); end
    checks++; if (SAMPLE_VALID !== 1'b0 || CLIP !== 1'b0 || OVERRUN !== 1'b0) begin errors++; $display("FAIL reset_flags got %b%b%b expected 000", SAMPLE_VALID, CLIP, OVERRUN); end
    checks++; if (FM_ENA !== 1'b0 || ACTIVE !== 1'b0) begin errors++; $display("FAIL reset_fm_active got %b%b expected 00", FM_ENA, ACTIVE); end
    checks++; if (DO !== CHIP_DO[15:8]) begin errors++; $display("FAIL reset_do got %h expected %h", DO, CHIP_DO[15:8]); end
    checks++; if (CHIP_WE !== 4'b0000 || CHIP_A0 !== 4'b1111) begin errors++; $display("FAIL reset_steer got we=%b a0=%b expected we=0000 a0=1111", CHIP_WE, CHIP_A0); end
    RESET = 1'b0;
    step();
  endtask

  task automatic test_commands();
    do_cmd(8'hFE);
    checks++; if (FM_ENA !== 1'b0) begin errors++; $display("FAIL cmd_fe_fm got %b expected 0", FM_ENA); end
    BDIR = 1'b1;
    BC = 1'b0;
    #1;
    checks++; if (CHIP_WE !== 4'b0001 || CHIP_A0 !== 4'b1111) begin errors++; $display("FAIL cmd_fe_steer got we=%b a0=%b expected we=0001 a0=1111", CHIP_WE, CHIP_A0); end
    BDIR = 1'b0;
    do_cmd(8'hE5);
    checks++; if (DO !== CHIP_DO[7:0]) begin errors++; $display("FAIL cmd_e5_ignored got %h expected %h", DO, CHIP_DO[7:0]); end
    do_cmd(8'hE3);
    CHIP_DO = $urandom;
    #1;
    checks++; if (DO !== CHIP_DO[31:24]) begin errors++; $display("FAIL cmd_e3_do got %h expected %h", DO, CHIP_DO[31:24]); end
    do_cmd(8'hFB);
    checks++; if (FM_ENA !== 1'b1) begin errors++; $display("FAIL cmd_fb_fm got %b expected 1", FM_ENA); end
  endtask

  task automatic test_steering();
    logic [NC-1:0] we, a0;
    for (int n = 0; n < 40; n++) begin
      do_cmd(rand_cmd());
      CHIP_DO = $urandom;
      PSG_ACT = 4'($urandom);
      BDIR = 1'($urandom);
      BC = 1'($urandom);
      DI = 8'h00;
      #1;
      we = BDIR ? 4'(1 << m_sel) : 4'b0000;
      for (int i = 0; i < NC; i++) a0[i] = we[i] ? ~BC : 1'(m_stat);
      checks++; if (CHIP_WE !== we || CHIP_A0 !== a0) begin errors++; $display("FAIL steer_we_a0 got we=%b a0=%b expected we=%b a0=%b", CHIP_WE, CHIP_A0, we, a0); end
      checks++; if (DO !== CHIP_DO[m_sel*8 +: 8]) begin errors++; $display("FAIL steer_do got %h expected %h", DO, CHIP_DO[m_sel*8 +: 8]); end
      checks++; if (FM_ENA !== 1'(m_fm) || ACTIVE !== ((|PSG_ACT) | 1'(m_fm))) begin errors++; $display("FAIL steer_fm_active got %b%b expected %b%b", FM_ENA, ACTIVE, 1'(m_fm), (|PSG_ACT) | 1'(m_fm)); end
      BDIR = 1'b0;
      BC = 1'b0;
    end
    load();
  endtask

  task automatic test_mix_basic();
    int el, er, lat, nv, ov;
    bit ec;
    logic signed [OW-1:0] l, r;
    logic clp;
    do_cmd(8'hFE);
    clear_chips();
    ca[0] = 16; cb[0] = 16; cc[0] = 16; cact[0] = 1'b1;
    ca[1] = 255;
    load();
    model_mix(m_fm, m_mode, el, er, ec);
    run_pass(0, 0, 1'b0, 8'h00, lat, nv, ov, l, r, clp);
    checks++; if (lat !== LAT || nv !== 1) begin errors++; $display("FAIL basic_latency got %0d (%0d pulses) expected %0d (1)", lat, nv, LAT); end
    checks++; if (l !== 12'h030 || r !== 12'h030 || l !== OW'(el)) begin errors++; $display("FAIL basic_lr got %0d/%0d expected 48/48", l, r); end
    checks++; if (clp !== 1'b0 || ov !== -1) begin errors++; $display("FAIL basic_clip_ovr got clip=%b ovr_at=%0d expected 0/-1", clp, ov); end
  endtask

  task automatic test_fm_clip();
    int el, er, lat, nv, ov;
    bit ec;
    logic signed [OW-1:0] l, r;
    logic clp;
    do_cmd(8'hFB);
    clear_chips();
    cf[0] = 2047; cf[1] = 2047;
    load();
    model_mix(m_fm, m_mode, el, er, ec);
    run_pass(0, 0, 1'b0, 8'h00, lat, nv, ov, l, r, clp);
    checks++; if (l !== OW'(el) || r !== OW'(er) || clp !== ec) begin errors++; $display("FAIL fm_clip_pos got %0d/%0d clip=%b expected %0d/%0d clip=%b", l, r, clp, el, er, ec); end
    for (int i = 0; i < NC; i++) cf[i] = -2048;
    load();
    model_mix(m_fm, m_mode, el, er, ec);
    run_pass(0, 0, 1'b0, 8'h00, lat, nv, ov, l, r, clp);
    checks++; if (l !== OW'(el) || r !== OW'(er) || clp !== ec) begin errors++; $display("FAIL fm_clip_neg got %0d/%0d clip=%b expected %0d/%0d clip=%b", l, r, clp, el, er, ec); end
  endtask

  task automatic test_modes();
    int el, er, lat, nv, ov;
    bit ec;
    logic signed [OW-1:0] l, r;
    logic clp;
    do_cmd(8'hFF);
    clear_chips();
    ca[0] = 1; cb[0] = 2; cc[0] = 3; cact[0] = 1'b1;
    cf[2] = 700;
    load();
    for (int md = 0; md < 4; md++) begin
      do_cmd(8'hD0 | 8'(md));
      model_mix(m_fm, m_mode, el, er, ec);
      run_pass(0, 0, 1'b0, 8'h00, lat, nv, ov, l, r, clp);
      checks++; if (l !== OW'(el) || r !== OW'(er) || clp !== ec) begin errors++; $display("FAIL mode_%0d got %0d/%0d expected %0d/%0d", md, l, r, el, er); end
    end
  endtask

  task automatic test_random();
    int el, er, lat, nv, ov;
    bit ec;
    logic signed [OW-1:0] l, r;
    logic clp;
    for (int n = 0; n < 30; n++) begin
      do_cmd(rand_cmd());
      rand_chips();
      model_mix(m_fm, m_mode, el, er, ec);
      run_pass(0, 0, 1'b0, 8'h00, lat, nv, ov, l, r, clp);
      checks++; if (lat !== LAT || nv !== 1 || ov !== -1) begin errors++; $display("FAIL rand_timing got lat=%0d pulses=%0d ovr=%0d expected %0d/1/-1", lat, nv, ov, LAT); end
      checks++; if (l !== OW'(el) || r !== OW'(er) || clp !== ec) begin errors++; $display("FAIL rand_mix got %0d/%0d clip=%b expected %0d/%0d clip=%b", l, r, clp, el, er, ec); end
    end
  endtask

  task automatic test_overrun();
    int el, er, lat, nv, ov;
    bit ec;
    logic signed [OW-1:0] l, r;
    logic clp;
    rand_chips();
    model_mix(m_fm, m_mode, el, er, ec);
    run_pass(2, 0, 1'b0, 8'h00, lat, nv, ov, l, r, clp);
    checks++; if (ov !== 3 || nv !== 1 || lat !== LAT) begin errors++; $display("FAIL overrun_accum got ovr=%0d pulses=%0d lat=%0d expected 3/1/%0d", ov, nv, lat, LAT); end
    checks++; if (l !== OW'(el) || r !== OW'(er)) begin errors++; $display("FAIL overrun_value got %0d/%0d expected %0d/%0d", l, r, el, er); end
    run_pass(LAT, 0, 1'b0, 8'h00, lat, nv, ov, l, r, clp);
    checks++; if (ov !== LAT + 1 || nv !== 1) begin errors++; $display("FAIL overrun_out got ovr=%0d pulses=%0d expected %0d/1", ov, nv, LAT + 1); end
  endtask

  task automatic test_cmd_with_ce();
    int el, er, lat, nv, ov;
    bit ec;
    logic signed [OW-1:0] l, r;
    logic clp;
    do_cmd(8'hFE);
    rand_chips();
    cf[0] = 1000;
    load();
    model_mix(m_fm, m_mode, el, er, ec);
    run_pass(0, 0, 1'b1, 8'hFB, lat, nv, ov, l, r, clp);
    checks++; if (l !== OW'(el) || r !== OW'(er) || clp !== ec) begin errors++; $display("FAIL simul_cmd_pass got %0d/%0d expected %0d/%0d", l, r, el, er); end
    checks++; if (FM_ENA !== 1'b1) begin errors++; $display("FAIL simul_cmd_fm got %b expected 1", FM_ENA); end
  endtask

  task automatic test_reset_mid();
    int el, er, lat, nv, ov;
    bit ec;
    logic signed [OW-1:0] l, r;
    logic clp;
    clear_chips();
    ca[0] = 100; cact[0] = 1'b1;
    load();
    run_pass(0, 2, 1'b0, 8'h00, lat, nv, ov, l, r, clp);
    checks++; if (nv !== 0) begin errors++; $display("FAIL reset_mid_valid got %0d pulses expected 0", nv); end
    checks++; if (CHANNEL_L !== '0 || CHANNEL_R !== '0 || FM_ENA !== 1'b0) begin errors++; $display("FAIL reset_mid_out got %0d/%0d fm=%b expected 0/0 fm=0", CHANNEL_L, CHANNEL_R, FM_ENA); end
    model_mix(m_fm, m_mode, el, er, ec);
    run_pass(0, 0, 1'b0, 8'h00, lat, nv, ov, l, r, clp);
    checks++; if (lat !== LAT || l !== OW'(el) || r !== OW'(er)) begin errors++; $display("FAIL reset_mid_next got lat=%0d %0d/%0d expected %0d %0d/%0d", lat, l, r, LAT, el, er); end
  endtask

  initial begin
    test_reset();
    test_commands();
    test_steering();
    test_mix_basic();
    test_fm_clip();
    test_modes();
    test_random();
    test_overrun();
    test_cmd_with_ce();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
